sub_bytes_sequencer: RTL and testbench

Sequencer that applies the AES SubBytes transformation to a full 128-bit state using a single shared one-byte `subBytes` S-box unit. It accepts a state over a valid/ready handshake, feeds its 16 bytes to the S-box one per cycle, collects the substituted bytes, and presents the result over a second valid/ready handshake. It sits between the round controller and the byte-wide S-box, replacing 16 parallel S-box instances.

---
 rtl/sub_bytes_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_sub_bytes_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_sequencer.sv
// Runs AES SubBytes over a 128-bit state through one shared byte-wide S-box.
// Optional SUBBYTES_SEQ_PERF_EN adds handshake and stall counters.
module sub_bytes_sequencer #(
    parameter int SBOX_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
`ifdef SUBBYTES_SEQ_PERF_EN
    output logic [15:0]  perf_blocks,
    output logic [15:0]  perf_stall,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [127:0]            in_buf_q, in_buf_d;
    logic [127:0]            res_q, res_d;
    logic [4:0]              iss_q, iss_d;
    logic [4:0]              cap_q, cap_d;
    logic [7:0]              sbox_in_q, sbox_in_d;
    logic [SBOX_LATENCY-1:0] dl_q, dl_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    logic                    feed_s;
    logic                    cap_fire_s;
    logic                    last_cap_s;
    logic                    out_hs_s;
    logic [6:0]              cap_sh_s;

    // Byte 0 is the MSB byte, so byte idx sits (15-idx)*8 bits above the LSB.
    function automatic logic [6:0] byte_shift(input logic [3:0] idx);
        return {4'd15 - idx, 3'b000};
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] idx);
        logic [127:0] t;
        t = s >> byte_shift(idx);
        return t[7:0];
    endfunction

    assign feed_s     = (state_q == ST_FEED);
    assign cap_fire_s = dl_q[SBOX_LATENCY-1] && (cap_q != 5'd16);
    assign last_cap_s = cap_fire_s && (cap_q == 5'd15);
    assign out_hs_s   = (state_q == ST_DONE) && out_ready;
    assign cap_sh_s   = byte_shift(cap_q[3:0]);

    // Delay line: one valid bit per issued byte, aligned with the S-box latency.
    if (SBOX_LATENCY == 1) begin : g_dl_single
        assign dl_d = feed_s;
    end else begin : g_dl_multi
        assign dl_d = {dl_q[SBOX_LATENCY-2:0], feed_s};
    end

    // Next-state, capture and output-register logic.
    always_comb begin
        state_d     = state_q;
        in_buf_d    = in_buf_q;
        res_d       = res_q;
        iss_d       = iss_q;
        cap_d       = cap_q;
        sbox_in_d   = sbox_in_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        if (cap_fire_s) begin
            res_d = (res_q & ~(128'hFF << cap_sh_s)) | ({120'd0, sbox_out} << cap_sh_s);
            cap_d = cap_q + 5'd1;
        end else begin
            res_d = res_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_FEED;
                    in_buf_d   = state_in;
                    iss_d      = 5'd0;
                    cap_d      = 5'd0;
                    sbox_in_d  = state_in[127:120];
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (iss_q == 5'd15) begin
                    state_d = ST_DRAIN;
                end else begin
                    iss_d     = iss_q + 5'd1;
                    sbox_in_d = get_byte(in_buf_q, iss_q[3:0] + 4'd1);
                end
            end
            ST_DRAIN: begin
                if (last_cap_s || (cap_q == 5'd16)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_buf_q    <= 128'd0;
            res_q       <= 128'd0;
            iss_q       <= 5'd0;
            cap_q       <= 5'd0;
            sbox_in_q   <= 8'h00;
            dl_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_buf_q    <= in_buf_d;
            res_q       <= res_d;
            iss_q       <= iss_d;
            cap_q       <= cap_d;
            sbox_in_q   <= sbox_in_d;
            dl_q        <= dl_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign state_out = res_q;
    assign sbox_in   = sbox_in_q;
    assign busy      = busy_q;

`ifdef SUBBYTES_SEQ_PERF_EN
    logic [15:0] perf_blocks_q, perf_blocks_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    // Block count wraps; stall count saturates.
    always_comb begin
        perf_blocks_d = perf_blocks_q;
        perf_stall_d  = perf_stall_q;
        if (out_hs_s) begin
            perf_blocks_d = perf_blocks_q + 16'd1;
        end else begin
            perf_blocks_d = perf_blocks_q;
        end
        if ((state_q == ST_DONE) && !out_ready && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_blocks_q <= 16'd0;
            perf_stall_q  <= 16'd0;
        end else begin
            perf_blocks_q <= perf_blocks_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_blocks = perf_blocks_q;
    assign perf_stall  = perf_stall_q;
`else
    logic unused_hs_s;
    assign unused_hs_s = out_hs_s;
`endif

endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// Randomized self-checking bench: two sequencers (S-box latency 1 and 3)
// checked against a GF(2^8)-derived S-box reference model.
module tb_sub_bytes_sequencer;

    logic         clk = 1'b0;
    logic         rst_a       [2];
    logic         in_valid_a  [2];
    logic         in_ready_a  [2];
    logic [127:0] state_in_a  [2];
    logic         out_valid_a [2];
    logic         out_ready_a [2];
    logic [127:0] state_out_a [2];
    logic [7:0]   sbox_in_a   [2];
    logic [7:0]   sbox_out_a  [2];
    logic         busy_a      [2];
`ifdef SUBBYTES_SEQ_PERF_EN
    logic [15:0]  perf_blocks_a [2];
    logic [15:0]  perf_stall_a  [2];
`endif

    logic [7:0]   sbox_tab [256];
    logic [7:0]   p0_q = 8'h00;
    logic [7:0]   p1_q = 8'h00;
    int           n_tests = 0;
    int           n_fail  = 0;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    always #5 clk = ~clk;

    sub_bytes_sequencer #(.SBOX_LATENCY(1)) dut (
        .clk(clk), .rst(rst_a[0]), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .state_in(state_in_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .state_out(state_out_a[0]), .sbox_in(sbox_in_a[0]), .sbox_out(sbox_out_a[0]),
`ifdef SUBBYTES_SEQ_PERF_EN
        .perf_blocks(perf_blocks_a[0]), .perf_stall(perf_stall_a[0]),
`endif
        .busy(busy_a[0])
    );

    sub_bytes_sequencer #(.SBOX_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst_a[1]), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .state_in(state_in_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .state_out(state_out_a[1]), .sbox_in(sbox_in_a[1]), .sbox_out(sbox_out_a[1]),
`ifdef SUBBYTES_SEQ_PERF_EN
        .perf_blocks(perf_blocks_a[1]), .perf_stall(perf_stall_a[1]),
`endif
        .busy(busy_a[1])
    );

    // S-box models: one register stage for dut, three for dut3.
    always @(posedge clk) begin
        sbox_out_a[0] <= sbox_tab[sbox_in_a[0]];
        p0_q          <= sbox_tab[sbox_in_a[1]];
        p1_q          <= p0_q;
        sbox_out_a[1] <= p1_q;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = x << 1;
            if (hi) x = x ^ 8'h1b;
            y  = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // Multiplicative inverse in GF(2^8) followed by the AES affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                              ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_tab[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic do_reset(input int d);
        rst_a[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a[d] = 1'b0;
        check_eq("reset_flags", {in_ready_a[d], out_valid_a[d], busy_a[d]}, 3'b100);
        check_eq("reset_data", {sbox_in_a[d], state_out_a[d]}, 136'd0);
    endtask

    task automatic run_block(input int d, input logic [127:0] st, input logic [127:0] exp,
                             input int stall, input string tag);
        int   n;
        logic flags_ok;
        logic sb_ok;
        logic hold_ok;
        check_eq({tag, "/in_ready"}, in_ready_a[d], 1'b1);
        in_valid_a[d]  = 1'b1;
        state_in_a[d]  = st;
        out_ready_a[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[d] = 1'b0;
        state_in_a[d] = ~st;
        n = 1; flags_ok = 1'b1; sb_ok = 1'b1;
        while (!out_valid_a[d] && n < 100) begin
            if (in_ready_a[d] !== 1'b0 || busy_a[d] !== 1'b1) flags_ok = 1'b0;
            if (n <= 16 && sbox_in_a[d] !== st[127-8*(n-1) -: 8]) sb_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check_eq({tag, "/latency"}, n, 17 + lat_of(d));
        check_eq({tag, "/busy_flags"}, flags_ok, 1'b1);
        check_eq({tag, "/sbox_in_order"}, sb_ok, 1'b1);
        hold_ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            if (out_valid_a[d] !== 1'b1 || in_ready_a[d] !== 1'b0 || state_out_a[d] !== exp)
                hold_ok = 1'b0;
            @(negedge clk);
        end
        if (stall > 0) check_eq({tag, "/backpressure_hold"}, hold_ok, 1'b1);
        check_eq({tag, "/state_out"}, state_out_a[d], exp);
        out_ready_a[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_a[d] = 1'b0;
        check_eq({tag, "/back_to_idle"}, {out_valid_a[d], in_ready_a[d], busy_a[d]}, 3'b010);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] st;
        build_sbox();
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b1; in_valid_a[d] = 1'b0; out_ready_a[d] = 1'b0;
            state_in_a[d] = 128'd0;
        end
        @(negedge clk);
        do_reset(0);
        do_reset(1);

        run_block(0, {8'h19, {15{8'h7c}}}, {8'hd4, {15{8'h10}}}, 0, "single_byte");
        run_block(0, FIPS_IN, FIPS_OUT, 0, "fips");
        run_block(0, 128'd0, {16{8'h63}}, 10, "backpressure");

        // Abort at byte 7 of FEED, then a fresh state right away.
        in_valid_a[0] = 1'b1; state_in_a[0] = 128'h00112233445566778899aabbccddeeff;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("abort_at_byte7", sbox_in_a[0], 8'h77);
        do_reset(0);
        run_block(0, FIPS_IN, FIPS_OUT, 0, "after_abort");

        // Reset and in_valid together: reset wins.
        rst_a[0] = 1'b1; in_valid_a[0] = 1'b1; state_in_a[0] = FIPS_IN;
        @(posedge clk);
        @(negedge clk);
        rst_a[0] = 1'b0; in_valid_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_beats_valid", {in_ready_a[0], busy_a[0], out_valid_a[0]}, 3'b100);

        st = {$urandom, $urandom, $urandom, $urandom};
        run_block(1, FIPS_IN, FIPS_OUT, 0, "lat3_first");
        run_block(1, st, sub_state(st), 0, "lat3_second");

        for (int r = 0; r < 12; r++) begin
            for (int d = 0; d < 2; d++) begin
                st = {$urandom, $urandom, $urandom, $urandom};
                run_block(d, st, sub_state(st), int'($urandom_range(0, 3)), "random");
            end
        end

`ifdef SUBBYTES_SEQ_PERF_EN
        do_reset(0);
        check_eq("perf_cleared", {perf_blocks_a[0], perf_stall_a[0]}, 32'd0);
        for (int b = 0; b < 3; b++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            run_block(0, st, sub_state(st), (b == 1) ? 5 : 0, "perf_block");
        end
        check_eq("perf_blocks", perf_blocks_a[0], 16'd3);
        check_eq("perf_stall", perf_stall_a[0], 16'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
